// File: rtl/si53xx_cfg_sequencer.sv
// si53xx_cfg_sequencer
//   Boot-time master for si53xx_spi_interface. Resets the interface, streams an
//   {addr,data} table from ROM as register writes, pulses the PLL reset, then
//   polls the status register until loss-of-lock clears or the poll budget runs out.
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   start             1-cycle pulse, accepted only when idle
//   busy/done/error   sequence status; done/error sticky until the next start
//   err_code          0 none, 1 write timeout, 2 read timeout, 3 no lock
//   rom_addr/rom_data table index / entry (entry valid one cycle after index)
//   if_*              request/response handshake to the SPI interface
//   pll_reset         PLL reset, active-high
module si53xx_cfg_sequencer #(
  parameter int unsigned ROM_AW       = 8,
  parameter int unsigned IF_RST_CYC   = 16,
  parameter int unsigned PLL_RST_CYC  = 100,
  parameter int unsigned POLL_GAP_CYC = 1000,
  parameter int unsigned MAX_POLLS    = 64,
  parameter int unsigned XFER_TMO_CYC = 4096,
  parameter logic [7:0]  STATUS_ADDR  = 8'hDA,
  parameter logic [7:0]  LOL_MASK     = 8'h10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              if_reset,
  output logic              if_read,
  output logic              if_write,
  output logic [7:0]        if_addr,
  output logic [7:0]        if_wdata,
  input  logic [7:0]        if_rdata,
  input  logic              if_done,
  output logic              pll_reset
);

  localparam int unsigned MAX_A   = (IF_RST_CYC > PLL_RST_CYC) ? IF_RST_CYC : PLL_RST_CYC;
  localparam int unsigned MAX_B   = (POLL_GAP_CYC > XFER_TMO_CYC) ? POLL_GAP_CYC : XFER_TMO_CYC;
  localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned POLL_W  = $clog2(MAX_POLLS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_IF_RST, S_FETCH, S_ROM_WAIT, S_WAIT_WR,
    S_PLL_RST, S_GAP, S_WAIT_RD, S_DONE, S_ERROR
  } state_t;

  state_t              r_state, w_state;
  logic [CNT_W-1:0]    r_cnt, w_cnt;
  logic [POLL_W-1:0]   r_poll, w_poll;
  logic                r_busy, w_busy, r_done, w_done, r_error, w_error;
  logic [1:0]          r_err_code, w_err_code;
  logic [ROM_AW-1:0]   r_rom_addr, w_rom_addr;
  logic                r_if_reset, w_if_reset, r_if_read, w_if_read, r_if_write, w_if_write;
  logic [7:0]          r_if_addr, w_if_addr, r_if_wdata, w_if_wdata;
  logic                r_pll_reset, w_pll_reset;

  // State and every output are registered together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_poll      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_err_code  <= 2'd0;
      r_rom_addr  <= '0;
      r_if_reset  <= 1'b1;
      r_if_read   <= 1'b0;
      r_if_write  <= 1'b0;
      r_if_addr   <= 8'h00;
      r_if_wdata  <= 8'h00;
      r_pll_reset <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cnt       <= w_cnt;
      r_poll      <= w_poll;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_error     <= w_error;
      r_err_code  <= w_err_code;
      r_rom_addr  <= w_rom_addr;
      r_if_reset  <= w_if_reset;
      r_if_read   <= w_if_read;
      r_if_write  <= w_if_write;
      r_if_addr   <= w_if_addr;
      r_if_wdata  <= w_if_wdata;
      r_pll_reset <= w_pll_reset;
    end
  end

  // Next-state and next-output logic; request strobes default low so each lasts one cycle.
  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_poll      = r_poll;
    w_busy      = r_busy;
    w_done      = r_done;
    w_error     = r_error;
    w_err_code  = r_err_code;
    w_rom_addr  = r_rom_addr;
    w_if_reset  = r_if_reset;
    w_if_read   = 1'b0;
    w_if_write  = 1'b0;
    w_if_addr   = r_if_addr;
    w_if_wdata  = r_if_wdata;
    w_pll_reset = r_pll_reset;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state    = S_IF_RST;
          w_busy     = 1'b1;
          w_done     = 1'b0;
          w_error    = 1'b0;
          w_err_code = 2'd0;
          w_rom_addr = '0;
          w_if_reset = 1'b1;
          w_cnt      = '0;
        end
      end
      S_IF_RST: begin
        if (r_cnt == CNT_W'(IF_RST_CYC - 1)) begin
          w_if_reset = 1'b0;
          w_cnt      = '0;
          w_state    = S_FETCH;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_FETCH: w_state = S_ROM_WAIT;
      S_ROM_WAIT: begin
        w_cnt = '0;
        if (rom_data == 16'hFFFF) begin
          w_pll_reset = 1'b1;
          w_state     = S_PLL_RST;
        end else begin
          w_if_addr  = rom_data[15:8];
          w_if_wdata = rom_data[7:0];
          w_if_write = 1'b1;
          w_state    = S_WAIT_WR;
        end
      end
      S_WAIT_WR: begin
        // Completion takes priority over a coincident timeout.
        if (if_done) begin
          w_cnt = '0;
          if (&r_rom_addr) begin
            w_pll_reset = 1'b1;
            w_state     = S_PLL_RST;
          end else begin
            w_rom_addr = r_rom_addr + ROM_AW'(1);
            w_state    = S_FETCH;
          end
        end else if (r_cnt == CNT_W'(XFER_TMO_CYC - 1)) begin
          w_err_code = 2'd1;
          w_state    = S_ERROR;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_PLL_RST: begin
        if (r_cnt == CNT_W'(PLL_RST_CYC - 1)) begin
          w_pll_reset = 1'b0;
          w_cnt       = '0;
          w_poll      = '0;
          w_state     = S_GAP;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(POLL_GAP_CYC - 1)) begin
          w_if_addr = STATUS_ADDR;
          w_if_read = 1'b1;
          w_cnt     = '0;
          w_state   = S_WAIT_RD;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_RD: begin
        if (if_done) begin
          w_cnt = '0;
          if ((if_rdata & LOL_MASK) == 8'h00) begin
            w_state = S_DONE;
          end else begin
            w_poll = r_poll + POLL_W'(1);
            if (r_poll == POLL_W'(MAX_POLLS - 1)) begin
              w_err_code = 2'd3;
              w_state    = S_ERROR;
            end else begin
              w_state = S_GAP;
            end
          end
        end else if (r_cnt == CNT_W'(XFER_TMO_CYC - 1)) begin
          w_err_code = 2'd2;
          w_state    = S_ERROR;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_cnt   = '0;
        w_state = S_IDLE;
      end
      S_ERROR: begin
        w_error     = 1'b1;
        w_busy      = 1'b0;
        w_if_reset  = 1'b1;
        w_pll_reset = 1'b0;
        w_cnt       = '0;
        w_state     = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign error     = r_error;
  assign err_code  = r_err_code;
  assign rom_addr  = r_rom_addr;
  assign if_reset  = r_if_reset;
  assign if_read   = r_if_read;
  assign if_write  = r_if_write;
  assign if_addr   = r_if_addr;
  assign if_wdata  = r_if_wdata;
  assign pll_reset = r_pll_reset;

endmodule

// File: tb/tb_si53xx_cfg_sequencer.sv
// tb_si53xx_cfg_sequencer
//   Directed bench: ROM and SPI-interface models around si53xx_cfg_sequencer,
//   with a short poll gap so the long lock-failure case stays brief.
module tb_si53xx_cfg_sequencer;

  localparam int unsigned POLL_GAP   = 200;
  localparam int unsigned PLL_CYC    = 100;
  localparam int unsigned TMO_CYC    = 4096;
  localparam int          K_DLY      = 8;
  localparam logic [7:0]  STATUS_ADR = 8'hDA;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, error, if_reset, if_read, if_write, pll_reset;
  logic [1:0]  err_code;
  logic [7:0]  rom_addr, if_addr, if_wdata;
  logic [15:0] rom_data = 16'h0000;
  logic [7:0]  if_rdata = 8'h00;
  logic        if_done  = 1'b0;

  si53xx_cfg_sequencer #(.POLL_GAP_CYC(POLL_GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .error(error), .err_code(err_code), .rom_addr(rom_addr), .rom_data(rom_data),
    .if_reset(if_reset), .if_read(if_read), .if_write(if_write), .if_addr(if_addr),
    .if_wdata(if_wdata), .if_rdata(if_rdata), .if_done(if_done), .pll_reset(pll_reset)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Synchronous ROM: entry appears one cycle after the address.
  logic [15:0] rom_mem [256];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Interface model: if_done K_DLY cycles after a request; write number drop_idx is never answered.
  int          n_wr = 0, n_rd = 0, n_viol = 0, n_badaddr = 0;
  int          drop_idx = -1, lol_until = 0;
  logic [15:0] wr_log [1024];
  int          rd_time [512];
  logic        m_pend = 1'b0;
  int          m_tmr = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pend   <= 1'b0;
      m_tmr    <= 0;
      if_done  <= 1'b0;
      if_rdata <= 8'h00;
    end else begin
      if_done <= 1'b0;
      if (m_pend) begin
        if (m_tmr <= 1) begin
          if_done <= 1'b1;
          m_pend  <= 1'b0;
        end else begin
          m_tmr <= m_tmr - 1;
        end
      end
      if ((if_write || if_read) && (m_pend || (if_write && if_read))) n_viol <= n_viol + 1;
      if (if_write) begin
        if (n_wr < 1024) wr_log[n_wr] <= {if_addr, if_wdata};
        n_wr <= n_wr + 1;
        if (n_wr != drop_idx) begin
          m_pend <= 1'b1;
          m_tmr  <= K_DLY;
        end
      end
      if (if_read) begin
        if (if_addr != STATUS_ADR) n_badaddr <= n_badaddr + 1;
        if (n_rd < 512) rd_time[n_rd] <= cyc;
        n_rd     <= n_rd + 1;
        if_rdata <= (n_rd < lol_until) ? 8'h10 : 8'h00;
        m_pend   <= 1'b1;
        m_tmr    <= K_DLY;
      end
    end
  end

  // PLL reset pulse monitor: pulse count and length of the last completed pulse.
  int   n_pll = 0, pll_run = 0, pll_len = 0;
  logic pll_q = 1'b0;
  always @(posedge clk) begin
    if (pll_reset && !pll_q) begin
      n_pll   <= n_pll + 1;
      pll_run <= 1;
    end else if (pll_reset) begin
      pll_run <= pll_run + 1;
    end
    if (!pll_reset && pll_q) pll_len <= pll_run;
    pll_q <= pll_reset;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait (bounded) for busy to drop; an expired budget is reported as a failure.
  task automatic run_wait(input string tag, input int budget, output int ncyc);
    ncyc = 0;
    while (busy && ncyc < budget) begin
      @(negedge clk);
      ncyc++;
    end
    check({tag, "_finished"}, 32'(busy), 32'd0);
  endtask

  task automatic load_short_table();
    for (int i = 0; i < 256; i++) rom_mem[i] = 16'hFFFF;
    rom_mem[0] = 16'h1234;
    rom_mem[1] = 16'h5678;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  int bw, br, bp, nc, mingap, d;

  initial begin
    load_short_table();
    repeat (3) @(negedge clk);
    // Reset values
    check("rst_busy", 32'(busy), 0);
    check("rst_if_reset", 32'(if_reset), 1);
    check("rst_outputs", {20'd0, done, error, err_code, if_read, if_write, pll_reset, rom_addr[4:0]}, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_if_reset", 32'(if_reset), 1);

    // Short table, lock on first poll, redundant start while busy
    bw = n_wr; br = n_rd; bp = n_pll; lol_until = n_rd;
    pulse_start();
    check("t1_busy", 32'(busy), 1);
    repeat (30) @(negedge clk);
    pulse_start();
    run_wait("t1", 2000, nc);
    nc += 32;
    check("t1_writes", 32'(n_wr - bw), 2);
    check("t1_wr0", 32'(wr_log[bw]), 32'h1234);
    check("t1_wr1", 32'(wr_log[bw+1]), 32'h5678);
    check("t1_pll_pulses", 32'(n_pll - bp), 1);
    check("t1_pll_len", 32'(pll_len), PLL_CYC);
    check("t1_reads", 32'(n_rd - br), 1);
    check("t1_status", {done, error, err_code, if_reset, pll_reset}, 6'b100000);
    check("t1_latency_ok", 32'(nc >= 340 && nc <= 370), 1);

    // Full 256-entry table without end marker
    for (int i = 0; i < 256; i++) rom_mem[i] = {8'(i), ~8'(i)};
    bw = n_wr; bp = n_pll;
    pulse_start();
    run_wait("t2", 10000, nc);
    check("t2_writes", 32'(n_wr - bw), 256);
    check("t2_first", 32'(wr_log[bw]), 32'h00FF);
    check("t2_last", 32'(wr_log[bw+255]), 32'hFF00);
    check("t2_rom_addr", 32'(rom_addr), 255);
    check("t2_pll_pulses", 32'(n_pll - bp), 1);
    check("t2_done", {done, error}, 2'b10);

    // Three loss-of-lock polls, then lock
    load_short_table();
    br = n_rd; lol_until = n_rd + 3;
    pulse_start();
    run_wait("t3", 3000, nc);
    check("t3_reads", 32'(n_rd - br), 4);
    mingap = 1 << 30;
    for (int k = 1; k < 4; k++) begin
      d = rd_time[br+k] - rd_time[br+k-1];
      if (d < mingap) mingap = d;
    end
    check("t3_spacing_ok", 32'(mingap >= int'(POLL_GAP)), 1);
    check("t3_done", {done, error, err_code}, 4'b1000);

    // Lock never achieved
    br = n_rd; lol_until = 1 << 30;
    pulse_start();
    run_wait("t4", 20000, nc);
    check("t4_reads", 32'(n_rd - br), 64);
    check("t4_err_code", 32'(err_code), 3);
    check("t4_flags", {done, error, if_reset, pll_reset}, 4'b0110);

    // Second write never completes, then a clean rerun
    lol_until = 0;
    bw = n_wr; br = n_rd; drop_idx = n_wr + 1;
    pulse_start();
    run_wait("t5", 6000, nc);
    check("t5_err_code", 32'(err_code), 1);
    check("t5_flags", {done, error, if_reset}, 3'b011);
    check("t5_writes", 32'(n_wr - bw), 2);
    check("t5_reads", 32'(n_rd - br), 0);
    check("t5_tmo_ok", 32'(nc >= 4110 && nc <= 4150), 1);
    drop_idx = -1;
    pulse_start();
    run_wait("t5b", 2000, nc);
    check("t5b_flags", {done, error, err_code}, 4'b1000);

    // Reset while a write is outstanding
    bw = n_wr;
    pulse_start();
    nc = 0;
    while (n_wr == bw && nc < 200) begin
      @(negedge clk);
      nc++;
    end
    check("t6_write_seen", 32'(n_wr > bw), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t6_rst_busy", {busy, done, if_write, if_reset}, 4'b0001);
    check("t6_rst_rom_addr", 32'(rom_addr), 0);
    check("t6_rst_if_bus", {if_addr, if_wdata}, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    bw = n_wr;
    repeat (100) @(negedge clk);
    check("t6_no_restart", {31'(n_wr - bw), busy}, 0);

    // Reset while PLL reset is asserted
    pulse_start();
    nc = 0;
    while (!pll_reset && nc < 500) begin
      @(negedge clk);
      nc++;
    end
    check("t7_pll_seen", 32'(pll_reset), 1);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("t7_rst_pll", {pll_reset, busy, if_reset}, 3'b001);
    check("t7_rst_if_addr", 32'(if_addr), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Recovery after reset
    bw = n_wr;
    pulse_start();
    run_wait("t8", 2000, nc);
    check("t8_flags", {done, error, err_code}, 4'b1000);
    check("t8_writes", 32'(n_wr - bw), 2);

    check("protocol_violations", 32'(n_viol), 0);
    check("read_addr_errors", 32'(n_badaddr), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
